// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sonar_pkg
// Purpose  : Shared definitions for the sonar control unit. Contains the FSM
//            state encoding, the frame character select codes and the frame
//            length.
// Revision : 1.0 - initial release
// ============================================================================
package sonar_pkg;

    // Values 9..15 are illegal. The FSM sends them back to INICIAL.
    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        MEDE          = 4'd2,
        ESPERA_MEDIDA = 4'd3,
        TRANSMITE     = 4'd4,
        ESPERA_TX     = 4'd5,
        FIM_FRAME     = 4'd6,
        ESPERA_TIMER  = 4'd7,
        PROX_POS      = 4'd8
    } state_t;

    // Character order within one serial frame.
    localparam logic [2:0] SEL_CENTENA_A  = 3'd0;  // angle hundreds
    localparam logic [2:0] SEL_DEZENA_A   = 3'd1;  // angle tens
    localparam logic [2:0] SEL_UNIDADE_A  = 3'd2;  // angle units
    localparam logic [2:0] SEL_VIRGULA    = 3'd3;  // ','
    localparam logic [2:0] SEL_CENTENA_D  = 3'd4;  // distance hundreds
    localparam logic [2:0] SEL_DEZENA_D   = 3'd5;  // distance tens
    localparam logic [2:0] SEL_UNIDADE_D  = 3'd6;  // distance units
    localparam logic [2:0] SEL_TERMINADOR = 3'd7;  // '#'

    localparam int N_CHARS = 8;

endpackage
`default_nettype wire

// File: rtl/watchdog_timer.sv
`default_nettype none
// ============================================================================
// Module   : watchdog_timer
// Purpose  : Up-counter that bounds a wait. It counts while enabled and holds
//            at TERMINAL-1. o_fim is high for as long as the terminal count
//            is held.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            i_clear        - synchronous clear (priority over enable)
//            i_enable       - count enable
//            o_fim          - terminal count reached
// Revision : 1.0 - initial release
// ============================================================================
module watchdog_timer #(
    parameter int TERMINAL = 1_500_000,
    parameter int W        = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_fim
);

    localparam logic [W-1:0] c_last = W'(TERMINAL - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The first enabled cycle is count 0. o_fim therefore rises after
    // TERMINAL-1 enabled cycles, and the caller leaves after TERMINAL cycles.
    assign o_fim = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/sonar_uc.sv
`default_nettype none
// ============================================================================
// Module   : sonar_uc
// Purpose  : Control unit for the sonar datapath. One scan step does the
//            following, in order:
//              - triggers a measurement;
//              - sends the 8-character frame over the serial link;
//              - waits out the dwell timer;
//              - steps the servo.
//            Steps repeat while ligar is high.
// Ports    : clock, reset          - 50 MHz clock, async active-high reset
//            ligar                 - scan enable (level)
//            pronto_medida         - measurement done pulse
//            pronto_serial         - character transmitted pulse
//            fim_timer             - dwell time elapsed
//            zera/conta_timer      - dwell timer clear / enable
//            zera/conta_posicao    - servo position clear / step
//            reset_servo           - sensor interface reset
//            medir, partida_serial - measurement / UART start strobes
//            sel_letra             - frame character select
//            pronto                - frame complete strobe
//            erro_medida           - frame carries a timed-out measurement
//            db_estado             - current state code
// Revision : 1.0 - initial release
// ============================================================================
module sonar_uc
    import sonar_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 1_500_000,
    parameter int TW           = 21
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto_medida,
    input  logic       pronto_serial,
    input  logic       fim_timer,
    output logic       zera_timer,
    output logic       conta_timer,
    output logic       zera_posicao,
    output logic       conta_posicao,
    output logic       reset_servo,
    output logic       medir,
    output logic       partida_serial,
    output logic [2:0] sel_letra,
    output logic       pronto,
    output logic       erro_medida,
    output logic [3:0] db_estado
);

    state_t     r_state;
    logic [2:0] r_sel;
    logic       r_erro;

    logic       w_wd_clear;
    logic       w_wd_enable;
    logic       w_wd_fim;

    // The measurement watchdog is armed in MEDE and runs only while the FSM
    // waits for pronto_medida.
    assign w_wd_clear  = (r_state == PREPARA) || (r_state == MEDE);
    assign w_wd_enable = (r_state == ESPERA_MEDIDA);

    watchdog_timer #(
        .TERMINAL (TIMEOUT_CLKS),
        .W        (TW)
    ) u_watchdog (
        .clk      (clock),
        .rst      (reset),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_fim    (w_wd_fim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= INICIAL;
            r_sel   <= SEL_CENTENA_A;
            r_erro  <= 1'b0;
        end else begin
            case (r_state)
                INICIAL: begin
                    if (ligar) r_state <= PREPARA;
                end
                PREPARA: begin
                    r_sel   <= SEL_CENTENA_A;
                    r_erro  <= 1'b0;
                    r_state <= MEDE;
                end
                MEDE: begin
                    r_erro  <= 1'b0;
                    r_state <= ESPERA_MEDIDA;
                end
                ESPERA_MEDIDA: begin
                    // A real measurement wins when it lands on the timeout cycle.
                    if (pronto_medida) begin
                        r_erro  <= 1'b0;
                        r_state <= TRANSMITE;
                    end else if (w_wd_fim) begin
                        r_erro  <= 1'b1;
                        r_state <= TRANSMITE;
                    end
                end
                TRANSMITE: begin
                    r_state <= ESPERA_TX;
                end
                ESPERA_TX: begin
                    if (pronto_serial) begin
                        if (r_sel == SEL_TERMINADOR) begin
                            r_state <= FIM_FRAME;
                        end else begin
                            r_sel   <= r_sel + 1'b1;
                            r_state <= TRANSMITE;
                        end
                    end
                end
                FIM_FRAME: begin
                    r_sel <= SEL_CENTENA_A;
                    if (ligar) begin
                        r_state <= ESPERA_TIMER;
                    end else begin
                        // Clear the flag so that the idle state shows no status.
                        r_erro  <= 1'b0;
                        r_state <= INICIAL;
                    end
                end
                ESPERA_TIMER: begin
                    // Stopping the scan takes priority over a dwell expiry.
                    if (!ligar) begin
                        r_erro  <= 1'b0;
                        r_state <= INICIAL;
                    end else if (fim_timer) begin
                        r_state <= PROX_POS;
                    end
                end
                PROX_POS: begin
                    r_state <= MEDE;
                end
                default: begin
                    r_sel   <= SEL_CENTENA_A;
                    r_erro  <= 1'b0;
                    r_state <= INICIAL;
                end
            endcase
        end
    end

    // Moore decode. Every strobe lasts exactly as long as its single-cycle
    // state does.
    always_comb begin
        zera_timer     = 1'b0;
        conta_timer    = 1'b0;
        zera_posicao   = 1'b0;
        conta_posicao  = 1'b0;
        reset_servo    = 1'b0;
        medir          = 1'b0;
        partida_serial = 1'b0;
        pronto         = 1'b0;
        case (r_state)
            PREPARA: begin
                zera_timer   = 1'b1;
                zera_posicao = 1'b1;
                reset_servo  = 1'b1;
            end
            MEDE:         medir          = 1'b1;
            TRANSMITE:    partida_serial = 1'b1;
            FIM_FRAME: begin
                pronto     = 1'b1;
                zera_timer = 1'b1;
            end
            ESPERA_TIMER: conta_timer    = 1'b1;
            PROX_POS:     conta_posicao  = 1'b1;
            default: ;
        endcase
    end

    assign sel_letra   = r_sel;
    assign erro_medida = r_erro;
    assign db_estado   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sonar_uc.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_uc
// Purpose  : Self-checking bench for sonar_uc. Scan frames use random
//            measurement, serial and dwell delays. The expected timing and
//            flags come from the frame rules. Pulse totals are compared
//            against the counts the bench expects.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonar_uc;

    localparam int TO = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ligar = 1'b0;
    logic       pronto_medida = 1'b0;
    logic       pronto_serial = 1'b0;
    logic       fim_timer = 1'b0;
    logic       zera_timer, conta_timer, zera_posicao, conta_posicao;
    logic       reset_servo, medir, partida_serial, pronto, erro_medida;
    logic [2:0] sel_letra;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_mis = 0;

    // Pulse totals: observed by the monitor, expected by the stimulus.
    int got_medir = 0, got_partida = 0, got_pronto = 0, got_cpos = 0, got_zpos = 0;
    int exp_medir = 0, exp_partida = 0, exp_pronto = 0, exp_cpos = 0, exp_zpos = 0;

    sonar_uc #(
        .TIMEOUT_CLKS (TO),
        .TW           (5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ligar          (ligar),
        .pronto_medida  (pronto_medida),
        .pronto_serial  (pronto_serial),
        .fim_timer      (fim_timer),
        .zera_timer     (zera_timer),
        .conta_timer    (conta_timer),
        .zera_posicao   (zera_posicao),
        .conta_posicao  (conta_posicao),
        .reset_servo    (reset_servo),
        .medir          (medir),
        .partida_serial (partida_serial),
        .sel_letra      (sel_letra),
        .pronto         (pronto),
        .erro_medida    (erro_medida),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    always @(negedge clock) begin
        if (!reset) begin
            got_medir   += int'(medir);
            got_partida += int'(partida_serial);
            got_pronto  += int'(pronto);
            got_cpos    += int'(conta_posicao);
            got_zpos    += int'(zera_posicao);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {zera_timer, conta_timer, zera_posicao, conta_posicao, reset_servo,
                medir, partida_serial, sel_letra, pronto, erro_medida, db_estado};
    endfunction

    // Entry: idle at a negedge. Exit: at the negedge of the MEDE cycle.
    task automatic start_scan();
        check_eq("idle_before_start", db_estado, 0);
        ligar = 1'b1;
        @(negedge clock);
        check_eq("prep_state", db_estado, 1);
        check_eq("prep_zera_posicao", zera_posicao, 1);
        check_eq("prep_zera_timer", zera_timer, 1);
        check_eq("prep_reset_servo", reset_servo, 1);
        exp_zpos++;
        @(negedge clock);
    endtask

    // Entry: at the negedge of a MEDE cycle. Exit: the next MEDE, or idle.
    //   meas_d     - ESPERA_MEDIDA cycle index of the pronto_medida pulse
    //   tx_fixed   - pronto_serial delay per char (-1 = random)
    //   drop_char  - char whose TRANSMITE drops ligar (-1 = never)
    //   timer_d    - ESPERA_TIMER cycle index of fim_timer
    //   drop_at_fim- drop ligar in the same cycle as fim_timer
    task automatic run_frame(input int meas_d, input int tx_fixed, input int drop_char,
                             input int timer_d, input bit drop_at_fim);
        int  exit_i;
        int  d;
        bit  exp_err;
        check_eq("mede_state", db_estado, 2);
        check_eq("mede_medir", medir, 1);
        exp_medir++;
        @(negedge clock);
        // Leaves after meas_d+1 cycles, or after TO cycles on timeout.
        exp_err = (meas_d > TO - 1);
        exit_i  = exp_err ? TO - 1 : meas_d;
        for (int i = 0; i <= exit_i; i++) begin
            if (i == 0) check_eq("espm_medir_off", medir, 0);
            if (i == 0 || i == exit_i) check_eq("espm_state", db_estado, 3);
            pronto_medida = (i == meas_d);
            @(negedge clock);
        end
        pronto_medida = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check_eq("tx_state", db_estado, 4);
            check_eq("tx_partida", partida_serial, 1);
            check_eq("tx_sel_letra", sel_letra, c);
            check_eq("tx_erro_medida", erro_medida, exp_err);
            exp_partida++;
            if (c == drop_char) ligar = 1'b0;
            pronto_serial = 1'($urandom_range(0, 1));  // stray pulse, must be ignored
            @(negedge clock);
            d = (tx_fixed >= 0) ? tx_fixed : int'($urandom_range(0, 12));
            for (int j = 0; j <= d; j++) begin
                if (j == 0) begin
                    check_eq("etx_state", db_estado, 5);
                    check_eq("etx_partida_off", partida_serial, 0);
                end
                pronto_serial = (j == d);
                pronto_medida = 1'($urandom_range(0, 1));  // stray, ignored
                @(negedge clock);
            end
            pronto_serial = 1'b0;
            pronto_medida = 1'b0;
        end
        check_eq("fim_state", db_estado, 6);
        check_eq("fim_pronto", pronto, 1);
        check_eq("fim_zera_timer", zera_timer, 1);
        check_eq("fim_erro_medida", erro_medida, exp_err);
        exp_pronto++;
        if (!ligar) begin
            @(negedge clock);
            check_eq("stop_after_frame_outs", outs(), 0);
            return;
        end
        @(negedge clock);
        for (int t = 0; t <= timer_d; t++) begin
            if (t == 0) begin
                check_eq("etim_state", db_estado, 7);
                check_eq("etim_conta_timer", conta_timer, 1);
                check_eq("etim_sel_cleared", sel_letra, 0);
                check_eq("etim_pronto_off", pronto, 0);
            end
            fim_timer     = (t == timer_d);
            pronto_serial = 1'($urandom_range(0, 1));  // stray, ignored
            if (t == timer_d && drop_at_fim) ligar = 1'b0;
            @(negedge clock);
        end
        fim_timer     = 1'b0;
        pronto_serial = 1'b0;
        if (drop_at_fim) begin
            check_eq("stop_in_timer_outs", outs(), 0);
            return;
        end
        check_eq("prox_state", db_estado, 8);
        check_eq("prox_conta_posicao", conta_posicao, 1);
        exp_cpos++;
        @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_eq("reset_outs", outs(), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("idle_hold_outs", outs(), 0);

        // Fixed-delay frame, a timeout frame, and a coincidence frame.
        start_scan();
        run_frame(4, 9, -1, 3, 1'b0);
        run_frame(99, -1, -1, int'($urandom_range(0, 5)), 1'b0);
        run_frame(TO - 1, -1, -1, int'($urandom_range(0, 5)), 1'b0);
        for (int f = 0; f < 5; f++)
            run_frame(int'($urandom_range(0, 25)), -1, -1, int'($urandom_range(0, 6)), 1'b0);
        // ligar drops while char 4 is sent. The frame still finishes.
        run_frame(int'($urandom_range(0, 25)), -1, 4, 0, 1'b0);

        // ligar drops in the same cycle as fim_timer. The drop takes priority.
        repeat (2) @(negedge clock);
        check_eq("idle_after_stop", db_estado, 0);
        start_scan();
        run_frame(int'($urandom_range(0, 25)), -1, -1, 2, 1'b1);

        // Reset asserted while the FSM waits in ESPERA_TX.
        @(negedge clock);
        start_scan();
        check_eq("rst_mede_medir", medir, 1);
        exp_medir++;
        @(negedge clock);
        pronto_medida = 1'b1;
        @(negedge clock);
        pronto_medida = 1'b0;
        check_eq("rst_tx_partida", partida_serial, 1);
        exp_partida++;
        repeat (2) @(negedge clock);
        check_eq("rst_etx_state", db_estado, 5);
        #2 reset = 1'b1;
        #1 check_eq("rst_async_outs", outs(), 0);
        @(negedge clock);
        reset = 1'b0;
        ligar = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_release_idle_outs", outs(), 0);

        check_eq("total_medir", got_medir, exp_medir);
        check_eq("total_partida", got_partida, exp_partida);
        check_eq("total_pronto", got_pronto, exp_pronto);
        check_eq("total_conta_posicao", got_cpos, exp_cpos);
        check_eq("total_zera_posicao", got_zpos, exp_zpos);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
